// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: one registered decoded instruction with valid/ready on both sides and flush.
// Optional retired-instruction counter enabled by defining DECODE_PERF_CNT_EN.

package alu_decode_pkg;
    localparam int ALU_OP_WIDTH = 4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 4'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd14;
endpackage

module alu_decode_stage
    import alu_decode_pkg::*;
#(
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [31:0]             pc_i,
    input  logic [31:0]             rs1_data_i,
    input  logic [31:0]             rs2_data_i,
    input  logic                    flush_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [31:0]             operand_a_o,
    output logic [31:0]             operand_b_o,
    output logic [31:0]             store_data_o,
    output logic [31:0]             imm_o,
    output logic [4:0]              rd_addr_o,
    output logic                    rd_we_o,
    output logic                    is_branch_o,
    output logic                    is_jump_o,
    output logic                    is_load_o,
    output logic                    is_store_o,
    output logic                    illegal_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]             retired_cnt_o
`endif
);

    if (RESET_PC_UNUSED != 0) begin : g_reset_pc_check
        $error("RESET_PC_UNUSED is reserved and must be 0");
    end

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign opcode = instr_i[6:2];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'd0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign shamt  = {27'd0, instr_i[24:20]};

    logic [ALU_OP_WIDTH-1:0] alu_op_next, alu_op_reg;
    logic [31:0] operand_a_next, operand_a_reg, operand_b_next, operand_b_reg;
    logic [31:0] store_data_next, store_data_reg, imm_next, imm_reg;
    logic [4:0]  rd_addr_reg;
    logic rd_we_next, rd_we_reg, is_branch_next, is_branch_reg, is_jump_next, is_jump_reg;
    logic is_load_next, is_load_reg, is_store_next, is_store_reg, illegal_next, illegal_reg;
    logic valid_reg, accept;

    always_comb begin
        alu_op_next     = ALU_PASS;
        operand_a_next  = '0;
        operand_b_next  = '0;
        store_data_next = '0;
        imm_next        = '0;
        rd_we_next      = 1'b0;
        is_branch_next  = 1'b0;
        is_jump_next    = 1'b0;
        is_load_next    = 1'b0;
        is_store_next   = 1'b0;
        illegal_next    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                operand_a_next = imm_u;
                rd_we_next     = 1'b1;
            end
            OPC_AUIPC: begin
                alu_op_next    = ALU_ADD;
                operand_a_next = pc_i;
                operand_b_next = imm_u;
                rd_we_next     = 1'b1;
            end
            OPC_OP_IMM: begin
                operand_a_next = rs1_data_i;
                operand_b_next = imm_i;
                rd_we_next     = 1'b1;
                case (funct3)
                    3'b000: alu_op_next = ALU_ADD;
                    3'b010: alu_op_next = ALU_LTS;
                    3'b011: alu_op_next = ALU_LTU;
                    3'b100: alu_op_next = ALU_XOR;
                    3'b110: alu_op_next = ALU_OR;
                    3'b111: alu_op_next = ALU_AND;
                    3'b001: begin
                        operand_b_next = shamt;
                        alu_op_next    = ALU_SLL;
                        illegal_next   = (funct7 != 7'b0000000);
                    end
                    default: begin
                        operand_b_next = shamt;
                        if (funct7 == 7'b0000000)      alu_op_next  = ALU_SRL;
                        else if (funct7 == 7'b0100000) alu_op_next  = ALU_SRA;
                        else                           illegal_next = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                operand_a_next = rs1_data_i;
                operand_b_next = rs2_data_i;
                rd_we_next     = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  alu_op_next = ALU_ADD;
                        3'b001:  alu_op_next = ALU_SLL;
                        3'b010:  alu_op_next = ALU_LTS;
                        3'b011:  alu_op_next = ALU_LTU;
                        3'b100:  alu_op_next = ALU_XOR;
                        3'b101:  alu_op_next = ALU_SRL;
                        3'b110:  alu_op_next = ALU_OR;
                        default: alu_op_next = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    alu_op_next = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    alu_op_next = ALU_SRA;
                end else begin
                    illegal_next = 1'b1;
                end
            end
            OPC_BRANCH: begin
                operand_a_next = rs1_data_i;
                operand_b_next = rs2_data_i;
                imm_next       = imm_b;
                is_branch_next = 1'b1;
                case (funct3)
                    3'b000:  alu_op_next  = ALU_EQ;
                    3'b001:  alu_op_next  = ALU_NE;
                    3'b100:  alu_op_next  = ALU_LTS;
                    3'b101:  alu_op_next  = ALU_GES;
                    3'b110:  alu_op_next  = ALU_LTU;
                    3'b111:  alu_op_next  = ALU_GEU;
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4 is computed by the ALU; the target adder lives in execute.
                alu_op_next    = ALU_ADD;
                operand_a_next = pc_i;
                operand_b_next = 32'd4;
                imm_next       = (opcode == OPC_JAL) ? imm_j : imm_i;
                is_jump_next   = 1'b1;
                rd_we_next     = 1'b1;
                illegal_next   = (opcode == OPC_JALR) && (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                alu_op_next    = ALU_ADD;
                operand_a_next = rs1_data_i;
                operand_b_next = imm_i;
                is_load_next   = 1'b1;
                rd_we_next     = 1'b1;
                illegal_next   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                alu_op_next     = ALU_ADD;
                operand_a_next  = rs1_data_i;
                operand_b_next  = imm_s;
                store_data_next = rs2_data_i;
                is_store_next   = 1'b1;
                illegal_next    = funct3[2] || (funct3 == 3'b011);
            end
            default: illegal_next = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) illegal_next = 1'b1;
        if (illegal_next) begin
            alu_op_next     = ALU_PASS;
            operand_a_next  = '0;
            operand_b_next  = '0;
            store_data_next = '0;
            imm_next        = '0;
            rd_we_next      = 1'b0;
            is_branch_next  = 1'b0;
            is_jump_next    = 1'b0;
            is_load_next    = 1'b0;
            is_store_next   = 1'b0;
        end
        if (instr_i[11:7] == 5'd0) rd_we_next = 1'b0;
    end

    assign instr_ready_o = !valid_reg || ex_ready_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg      <= 1'b0;
            alu_op_reg     <= ALU_PASS;
            operand_a_reg  <= '0;
            operand_b_reg  <= '0;
            store_data_reg <= '0;
            imm_reg        <= '0;
            rd_addr_reg    <= '0;
            rd_we_reg      <= 1'b0;
            is_branch_reg  <= 1'b0;
            is_jump_reg    <= 1'b0;
            is_load_reg    <= 1'b0;
            is_store_reg   <= 1'b0;
            illegal_reg    <= 1'b0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg      <= 1'b1;
            alu_op_reg     <= alu_op_next;
            operand_a_reg  <= operand_a_next;
            operand_b_reg  <= operand_b_next;
            store_data_reg <= store_data_next;
            imm_reg        <= imm_next;
            rd_addr_reg    <= instr_i[11:7];
            rd_we_reg      <= rd_we_next;
            is_branch_reg  <= is_branch_next;
            is_jump_reg    <= is_jump_next;
            is_load_reg    <= is_load_next;
            is_store_reg   <= is_store_next;
            illegal_reg    <= illegal_next;
        end else if (ex_ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign ex_valid_o   = valid_reg;
    assign alu_op_o     = alu_op_reg;
    assign operand_a_o  = operand_a_reg;
    assign operand_b_o  = operand_b_reg;
    assign store_data_o = store_data_reg;
    assign imm_o        = imm_reg;
    assign rd_addr_o    = rd_addr_reg;
    assign rd_we_o      = rd_we_reg;
    assign is_branch_o  = is_branch_reg;
    assign is_jump_o    = is_jump_reg;
    assign is_load_o    = is_load_reg;
    assign is_store_o   = is_store_reg;
    assign illegal_o    = illegal_reg;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] retired_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i)                        retired_cnt_reg <= '0;
        else if (valid_reg && ex_ready_i) retired_cnt_reg <= retired_cnt_reg + 32'd1;
    end

    assign retired_cnt_o = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage; expectations are hand-decoded constants pushed at drive time.
// Define DECODE_PERF_CNT_EN to also exercise the retired-instruction counter.

module tb_alu_decode_stage;
    import alu_decode_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, instr_valid, instr_ready, flush, ex_valid, ex_ready;
    logic [31:0]             instr, pc, rs1, rs2;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [31:0]             op_a, op_b, store_data, imm;
    logic [4:0]              rd_addr;
    logic                    rd_we, is_branch, is_jump, is_load, is_store, illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]             retired_cnt;
`endif

    alu_decode_stage #(.RESET_PC_UNUSED(0)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2), .flush_i(flush),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .alu_op_o(alu_op),
        .operand_a_o(op_a), .operand_b_o(op_b), .store_data_o(store_data), .imm_o(imm),
        .rd_addr_o(rd_addr), .rd_we_o(rd_we), .is_branch_o(is_branch), .is_jump_o(is_jump),
        .is_load_o(is_load), .is_store_o(is_store), .illegal_o(illegal)
`ifdef DECODE_PERF_CNT_EN
        , .retired_cnt_o(retired_cnt)
`endif
    );

    // Field order: op, A, B, imm, store_data, rd, {rd_we, branch, jump, load, store, illegal}
    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] op;
        logic [31:0] a, b, imm, sd;
        logic [4:0]  rd;
        logic [5:0]  flags;
    } exp_t;
    typedef struct packed {
        exp_t v;
        exp_t m;
    } sb_t;

    sb_t  sb_q[$];
    exp_t obs, full_mask, ill_mask, reset_val;
    int   checks = 0;
    int   errors = 0;

    assign obs = {alu_op, op_a, op_b, imm, store_data, rd_addr,
                  rd_we, is_branch, is_jump, is_load, is_store, illegal};

    function automatic exp_t mk(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, b, im, sd,
                                input logic [4:0] rd, input logic [5:0] flags);
        return {op, a, b, im, sd, rd, flags};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        instr_valid = 1'b1;
        instr       = ins;
        rs1         = r1;
        rs2         = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; ex_ready = 1'b0; pc = 32'h100;
        drive(32'hFFF08293, 32'd10, 32'd0);
        step(); step();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        checks++;
        if (obs !== reset_val) begin errors++; $display("FAIL reset_fields: got %h want %h", obs, reset_val); end
        rst = 1'b0; flush = 1'b0; instr_valid = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        $display("txn reset done");
    endtask

    task automatic test_addi();
        sb_t s;
        ex_ready = 1'b1;
        drive(32'hFFF08293, 32'd10, 32'd0);
        sb_q.push_back({mk(ALU_ADD, 32'd10, 32'hFFFFFFFF, 0, 0, 5'd5, 6'b100000), full_mask});
        step();
        instr_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
        if (sb_q.size() == 0) begin errors++; $display("FAIL addi_sb: queue empty"); end
        else begin
            s = sb_q.pop_front(); checks++;
            if ((obs & s.m) !== (s.v & s.m)) begin errors++; $display("FAIL addi: got %h want %h", obs, s.v); end
            else $display("txn addi op=%0d a=%h b=%h", alu_op, op_a, op_b);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_stall();
        sb_t s;
        ex_ready = 1'b0;
        drive(32'h402081B3, 32'd20, 32'd7);
        sb_q.push_back({mk(ALU_SUB, 32'd20, 32'd7, 0, 0, 5'd3, 6'b100000), full_mask});
        step();
        // Next instruction waits upstream with different register data; SUB must not change.
        drive(32'h0020C333, 32'h0000F0F0, 32'h00000FF0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ex_valid !== 1'b1 || instr_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hs%0d: valid=%b ready=%b want 1/0", k, ex_valid, instr_ready);
            end
            checks++;
            if ((obs & sb_q[0].m) !== (sb_q[0].v & sb_q[0].m)) begin
                errors++; $display("FAIL stall_hold%0d: got %h want %h", k, obs, sb_q[0].v);
            end
            step();
        end
        sb_q.push_back({mk(ALU_XOR, 32'h0000F0F0, 32'h00000FF0, 0, 0, 5'd6, 6'b100000), full_mask});
        ex_ready = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", instr_ready); end
        s = sb_q.pop_front(); checks++;
        if ((obs & s.m) !== (s.v & s.m)) begin errors++; $display("FAIL stall_sub: got %h want %h", obs, s.v); end
        else $display("txn sub op=%0d a=%h b=%h", alu_op, op_a, op_b);
        step();
        instr_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b want 1", ex_valid); end
        s = sb_q.pop_front(); checks++;
        if ((obs & s.m) !== (s.v & s.m)) begin errors++; $display("FAIL stall_xor: got %h want %h", obs, s.v); end
        else $display("txn xor op=%0d a=%h b=%h", alu_op, op_a, op_b);
        step();
    endtask

    task automatic test_branch();
        sb_t s;
        ex_ready = 1'b1;
        drive(32'hFE20FCE3, 32'd5, 32'd5);
        sb_q.push_back({mk(ALU_GEU, 32'd5, 32'd5, 32'hFFFFFFF8, 0, 5'd25, 6'b010000), full_mask});
        step();
        instr_valid = 1'b0;
        s = sb_q.pop_front(); checks++;
        if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
            errors++; $display("FAIL bgeu: valid=%b got %h want %h", ex_valid, obs, s.v);
        end else $display("txn bgeu op=%0d imm=%h", alu_op, imm);
        step();
    endtask

    task automatic test_shift();
        sb_t s;
        ex_ready = 1'b1;
        drive(32'h4030D093, 32'h80000000, 32'd0);
        sb_q.push_back({mk(ALU_SRA, 32'h80000000, 32'd3, 0, 0, 5'd1, 6'b100000), full_mask});
        step();
        drive(32'h2030D093, 32'h80000000, 32'd0);
        sb_q.push_back({mk(ALU_PASS, 0, 0, 0, 0, 5'd0, 6'b000001), ill_mask});
        s = sb_q.pop_front(); checks++;
        if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
            errors++; $display("FAIL srai: valid=%b got %h want %h", ex_valid, obs, s.v);
        end else $display("txn srai op=%0d b=%h", alu_op, op_b);
        step();
        instr_valid = 1'b0;
        s = sb_q.pop_front(); checks++;
        if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
            errors++; $display("FAIL srai_bad_funct7: valid=%b got %h want %h", ex_valid, obs & s.m, s.v);
        end else $display("txn srai_bad_funct7 illegal=%b", illegal);
        step();
    endtask

    task automatic test_flush();
        sb_t s;
        ex_ready = 1'b1;
        drive(32'h12345037, 32'hAAAA5555, 32'd0);
        sb_q.push_back({mk(ALU_PASS, 32'h12345000, 0, 0, 0, 5'd0, 6'b000000), full_mask});
        step();
        s = sb_q.pop_front(); checks++;
        if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
            errors++; $display("FAIL lui_x0: valid=%b got %h want %h", ex_valid, obs, s.v);
        end else $display("txn lui_x0 a=%h rd_we=%b", op_a, rd_we);
        flush = 1'b1;
        drive(32'hFFF08293, 32'd10, 32'd0);
        step();
        flush = 1'b0; instr_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b want 0", ex_valid); end
        ex_ready = 1'b0; pc = 32'h400;
        drive(32'h00001397, 32'd0, 32'd0);
        sb_q.push_back({mk(ALU_ADD, 32'h400, 32'h1000, 0, 0, 5'd7, 6'b100000), full_mask});
        step();
        s = sb_q.pop_front(); checks++;
        if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
            errors++; $display("FAIL auipc: valid=%b got %h want %h", ex_valid, obs, s.v);
        end else $display("txn auipc a=%h b=%h", op_a, op_b);
        flush = 1'b1;
        drive(32'hFFF08293, 32'd10, 32'd0);
        step();
        flush = 1'b0; instr_valid = 1'b0; ex_ready = 1'b1;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b want 0", ex_valid); end
        step();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b want 0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        sb_t s;
        logic [31:0] words [4];
        logic [31:0] r1s [4];
        logic [31:0] r2s [4];
        sb_t exps [4];
        words[0] = 32'h010000EF; r1s[0] = 32'h0;    r2s[0] = 32'h0;
        words[1] = 32'hFFC1A103; r1s[1] = 32'h1000; r2s[1] = 32'h0;
        words[2] = 32'h00532423; r1s[2] = 32'h2000; r2s[2] = 32'hDEADBEEF;
        words[3] = 32'h00000001; r1s[3] = 32'h1234; r2s[3] = 32'h5678;
        exps[0] = {mk(ALU_ADD, 32'h200, 32'd4, 32'd16, 0, 5'd1, 6'b101000), full_mask};
        exps[1] = {mk(ALU_ADD, 32'h1000, 32'hFFFFFFFC, 0, 0, 5'd2, 6'b100100), full_mask};
        exps[2] = {mk(ALU_ADD, 32'h2000, 32'd8, 0, 32'hDEADBEEF, 5'd8, 6'b000010), full_mask};
        exps[3] = {mk(ALU_PASS, 0, 0, 0, 0, 5'd0, 6'b000001), ill_mask};
        ex_ready = 1'b1; pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            drive(words[i], r1s[i], r2s[i]);
            sb_q.push_back(exps[i]);
            step();
            if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_%0d: queue empty", i); end
            else begin
                s = sb_q.pop_front(); checks++;
                if (ex_valid !== 1'b1 || (obs & s.m) !== (s.v & s.m)) begin
                    errors++; $display("FAIL b2b_%0d: valid=%b got %h want %h", i, ex_valid, obs & s.m, s.v);
                end else $display("txn b2b_%0d instr=%h op=%0d a=%h b=%h", i, words[i], alu_op, op_a, op_b);
            end
        end
        instr_valid = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", ex_valid); end
    endtask

`ifdef DECODE_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (retired_cnt !== 32'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", retired_cnt); end
        ex_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'hFFF08293, i, 32'd0);
            step();
        end
        instr_valid = 1'b0;
        step();
        checks++;
        if (retired_cnt !== 32'd5) begin errors++; $display("FAIL cnt_five: got %0d want 5", retired_cnt); end
        else $display("txn perf_cnt retired=%0d", retired_cnt);
    endtask
`endif

    task automatic test_reset_mid_stall();
        ex_ready = 1'b0;
        drive(32'hFFF08293, 32'd10, 32'd0);
        step();
        instr_valid = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", ex_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ex_valid); end
        checks++;
        if (obs !== reset_val) begin errors++; $display("FAIL midrst_fields: got %h want %h", obs, reset_val); end
`ifdef DECODE_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", retired_cnt); end
`endif
        $display("txn reset_mid_stall done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        full_mask = '1;
        ill_mask  = mk({ALU_OP_WIDTH{1'b1}}, 0, 0, 0, 0, 5'd0, 6'b111111);
        reset_val = mk(ALU_PASS, 0, 0, 0, 0, 5'd0, 6'b000000);
        instr_valid = 1'b0; instr = '0; rs1 = '0; rs2 = '0;
        test_reset();
        test_addi();
        test_stall();
        test_branch();
        test_shift();
        test_flush();
        test_back_to_back();
`ifdef DECODE_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_reset_mid_stall();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
